// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback, drives datapath enables and muxes, counts retirements.
module mips_multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             InstrDone,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetiredCount
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state;
  logic [3:0] next_state;
  // Load/store distinction is latched in DECODE so MEMADR never looks at Opcode.
  logic       is_load;

  logic       c_pc_write;
  logic       c_pc_write_cond;
  logic       c_iord;
  logic       c_mem_read;
  logic       c_mem_write;
  logic       c_ir_write;
  logic       c_mem_to_reg;
  logic       c_reg_dst;
  logic       c_reg_write;
  logic       c_alu_src_a;
  logic [1:0] c_alu_src_b;
  logic [1:0] c_alu_op;
  logic [1:0] c_pc_source;
  logic       c_instr_done;
  logic       c_illegal_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      is_load      <= 1'b0;
      RetiredCount <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        is_load <= (Opcode == OP_LW);
      end
      if (InstrDone) begin
        RetiredCount <= RetiredCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    c_pc_write      = 1'b0;
    c_pc_write_cond = 1'b0;
    c_iord          = 1'b0;
    c_mem_read      = 1'b0;
    c_mem_write     = 1'b0;
    c_ir_write      = 1'b0;
    c_mem_to_reg    = 1'b0;
    c_reg_dst       = 1'b0;
    c_reg_write     = 1'b0;
    c_alu_src_a     = 1'b0;
    c_alu_src_b     = 2'b00;
    c_alu_op        = 2'b00;
    c_pc_source     = 2'b00;
    c_instr_done    = 1'b0;
    c_illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        c_mem_read  = 1'b1;
        c_alu_src_b = 2'b01;
        c_ir_write  = MemReady;
        c_pc_write  = MemReady;
      end
      S_DECODE: begin
        c_alu_src_b = 2'b11;
        case (Opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: c_illegal_op = 1'b0;
          default:                                   c_illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c_mem_read = 1'b1;
        c_iord     = 1'b1;
      end
      S_MEMWB: begin
        c_reg_write  = 1'b1;
        c_mem_to_reg = 1'b1;
        c_instr_done = 1'b1;
      end
      S_MEMWR: begin
        c_mem_write  = 1'b1;
        c_iord       = 1'b1;
        c_instr_done = MemReady;
      end
      S_EXECUTE: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c_reg_write  = 1'b1;
        c_reg_dst    = 1'b1;
        c_instr_done = 1'b1;
      end
      S_BRANCH: begin
        c_alu_src_a     = 1'b1;
        c_alu_op        = 2'b01;
        c_pc_write_cond = 1'b1;
        c_pc_source     = 2'b01;
        c_instr_done    = 1'b1;
      end
      S_ADDIEX: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        c_reg_write  = 1'b1;
        c_instr_done = 1'b1;
      end
      S_JUMP: begin
        c_pc_write   = 1'b1;
        c_pc_source  = 2'b10;
        c_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every strobe immediately so an abandoned instruction cannot write.
  always_comb begin
    PCWrite     = rst ? 1'b0  : c_pc_write;
    PCWriteCond = rst ? 1'b0  : c_pc_write_cond;
    IorD        = rst ? 1'b0  : c_iord;
    MemRead     = rst ? 1'b0  : c_mem_read;
    MemWrite    = rst ? 1'b0  : c_mem_write;
    IRWrite     = rst ? 1'b0  : c_ir_write;
    MemtoReg    = rst ? 1'b0  : c_mem_to_reg;
    RegDst      = rst ? 1'b0  : c_reg_dst;
    RegWrite    = rst ? 1'b0  : c_reg_write;
    ALUSrcA     = rst ? 1'b0  : c_alu_src_a;
    ALUSrcB     = rst ? 2'b00 : c_alu_src_b;
    ALUOp       = rst ? 2'b00 : c_alu_op;
    PCSource    = rst ? 2'b00 : c_pc_source;
    InstrDone   = rst ? 1'b0  : c_instr_done;
    IllegalOp   = rst ? 1'b0  : c_illegal_op;
  end

  assign State = state;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and multiplexer selects, and supplies the 2-bit `ALUOp` consumed directly by `ALUControl` (00 = add, 01 = subtract, 10 = decode funct field). A memory-ready handshake allows stalls on multi-cycle memory.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `Opcode`  in  6  instruction[31:26] from the instruction register
- `MemReady`  in  1  memory has completed the current read/write this cycle
- `PCWrite`  out  1  unconditional PC write
- `PCWriteCond`  out  1  PC write if ALU Zero (beq)
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  instruction register load
- `MemtoReg`  out  1  register write data: 0 = ALUOut, 1 = MDR
- `RegDst`  out  1  destination: 0 = rt, 1 = rd
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  0 = PC, 1 = A
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `ALUOp`  out  2  to `ALUControl`
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `InstrDone`  out  1  one-cycle pulse in the final cycle of each legal instruction
- `IllegalOp`  out  1  one-cycle pulse when an unsupported opcode is decoded
- `State`  out  4  current state (debug)
- `RetiredCount`  out  CNT_W  count of legal instructions completed

## Operation
- Moore FSM, 4-bit state register; outputs decode combinationally from state, gated by `MemReady` where noted. Any output not listed for a state is 0.
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
  - all others are illegal.
- States and outputs:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=MemReady. Stays while !MemReady; else → DECODE.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEMADR
    - R → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - illegal → FETCH with IllegalOp=1.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEMRD (lw) or MEMWR (sw).
  - MEMRD (3): MemRead=1, IorD=1; waits for MemReady → MEMWB.
  - MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1 → FETCH.
  - MEMWR (5): MemWrite=1, IorD=1; waits; InstrDone=MemReady; → FETCH when MemReady.
  - EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
  - ALUWB (7): RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1 → FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1 → FETCH.
  - ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
  - ADDIWB (10): RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1 → FETCH.
  - JUMP (11): PCWrite=1, PCSource=10, InstrDone=1 → FETCH.
  - Encodings 12–15 are unreachable; if entered, go to FETCH next cycle with no outputs asserted.
- `RetiredCount` increments by 1 on each edge where InstrDone=1. It wraps from 2^CNT_W−1 to 0. It does not count illegal opcodes.
- `Opcode` is sampled only in DECODE. The IR is stable there because IRWrite was asserted in FETCH.

## Timing
- Reset:
  - On an edge with rst=1: State=FETCH, RetiredCount=0.
  - While rst=1, all control outputs, InstrDone and IllegalOp are forced to 0.
  - Reset mid-instruction abandons it: no writes occur after the reset edge, and the first fetch begins the cycle after rst deasserts.
- Cycles per instruction with MemReady held at 1:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3
  - illegal 2 (FETCH, DECODE)
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. During a stall, MemRead/MemWrite/IorD are held and IRWrite/PCWrite stay 0.
- MemReady is ignored in all other states.
- InstrDone and the RetiredCount update coincide: the count is visible the cycle after the InstrDone pulse.

## Test plan
- Reset: assert rst for 2 cycles mid-way through an lw in MEMRD → all outputs 0 during reset; State=0 and RetiredCount=0 after; no RegWrite is issued.
- Back-to-back R-type (000000), addi (001000), j (000010) with MemReady=1:
  - State sequence 0,1,6,7,0,1,9,10,0,1,11,0.
  - ALUOp=10 in EXECUTE, 01 never.
  - RetiredCount=3 after 11 cycles.
- lw with MemReady low for 3 cycles in MEMRD:
  - lw takes 8 cycles total.
  - MemRead=1, IorD=1 throughout the stall.
  - RegWrite=1 with MemtoReg=1 only in MEMWB.
- sw with MemReady=0 for 2 cycles in FETCH then 1 cycle in MEMWR:
  - IRWrite/PCWrite pulse only on the ready cycle.
  - InstrDone pulses once with MemWrite=1; 7 cycles total.
- beq → ALUOp=01, PCWriteCond=1, PCSource=01 in state 8; 3 cycles; InstrDone=1.
- Illegal opcode 111111 → IllegalOp pulses in DECODE; returns to FETCH; RetiredCount unchanged.
- Counter wrap with CNT_W=4: 16 R-type instructions → RetiredCount returns to 0.
